// File: rtl/hdmi_video_pkg.sv
// Shared video definitions: 720p60 timing, pattern select codes, bar colours.
package hdmi_video_pkg;

  // 720p60 timing
  localparam int H_ACTIVE_720 = 1280;
  localparam int H_FP_720     = 110;
  localparam int H_SYNC_720   = 40;
  localparam int H_BP_720     = 220;
  localparam int V_ACTIVE_720 = 720;
  localparam int V_FP_720     = 5;
  localparam int V_SYNC_720   = 5;
  localparam int V_BP_720     = 20;
  localparam int H_TOTAL_720  = H_SYNC_720 + H_BP_720 + H_ACTIVE_720 + H_FP_720;
  localparam int V_TOTAL_720  = V_SYNC_720 + V_BP_720 + V_ACTIVE_720 + V_FP_720;

  // pat_sel encoding
  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_GRID  = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  // colour bar palette, left to right
  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  localparam int BOX_SIZE = 64;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Counter width: at least 8 bits so x[7:0] / y[5:0] slices always exist.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 8) ? 8 : $clog2(n);
  endfunction

  // Bar index 0..7 maps to the palette; anything past the last bar is black.
  function automatic logic [23:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return COL_WHITE;
      4'd1:    return COL_YELLOW;
      4'd2:    return COL_CYAN;
      4'd3:    return COL_GREEN;
      4'd4:    return COL_MAGENTA;
      4'd5:    return COL_RED;
      4'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_pattern_gen_timing.sv
// video_timing_ctrl: h/v counters with raw sync/de decode, pixel coordinates
// and a strobe on the first active pixel of each frame.
module video_timing_ctrl
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720,
  parameter int H_FP     = H_FP_720,
  parameter int H_SYNC   = H_SYNC_720,
  parameter int H_BP     = H_BP_720,
  parameter int V_ACTIVE = V_ACTIVE_720,
  parameter int V_FP     = V_FP_720,
  parameter int V_SYNC   = V_SYNC_720,
  parameter int V_BP     = V_BP_720,
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP,
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP,
  localparam int HW      = cnt_w(H_TOTAL + 1),
  localparam int VW      = cnt_w(V_TOTAL + 1)
) (
  input  logic          pixclk_in,
  input  logic          rst_n,
  input  logic          init_over,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          de_raw,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          sof,
  output logic          bar_clr
);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [HW-1:0] H_START_C = HW'(H_SYNC + H_BP);
  localparam logic [VW-1:0] V_START_C = VW'(V_SYNC + V_BP);
  localparam logic [HW-1:0] H_END_C   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_END_C   = VW'(V_SYNC + V_BP + V_ACTIVE);

  logic h_act, v_act;

  // Raster counters; held at the origin until configuration is done.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!init_over) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Raw decode of the current counter state.
  always_comb begin
    hs_raw  = (h_cnt < H_SYNC_C);
    vs_raw  = (v_cnt < V_SYNC_C);
    h_act   = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
    v_act   = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
    de_raw  = h_act && v_act;
    x       = h_cnt - H_START_C;
    y       = v_cnt - V_START_C;
    sof     = (h_cnt == H_START_C) && (v_cnt == V_START_C);
    // one pixel before x=0: lets the bar counter start cleanly at x=0
    bar_clr = (h_cnt == H_START_C - 1'b1);
  end

endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: video timing plus test-pattern source for the HDMI pixel
// stream. All outputs are registered one cycle after the counter state.
// Optional build macro HDMI_PAT_MOVING_BOX_EN overlays a bouncing 64x64 white
// box (needs H_ACTIVE and V_ACTIVE of at least 64).
module hdmi_pattern_gen
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720,
  parameter int H_FP     = H_FP_720,
  parameter int H_SYNC   = H_SYNC_720,
  parameter int H_BP     = H_BP_720,
  parameter int V_ACTIVE = V_ACTIVE_720,
  parameter int V_FP     = V_FP_720,
  parameter int V_SYNC   = V_SYNC_720,
  parameter int V_BP     = V_BP_720,
  parameter int SYNC_POL = 1
) (
  input  logic        pixclk_in,
  input  logic        rst_n,
  input  logic        init_over,
  input  logic [1:0]  pat_sel,
  input  logic [23:0] solid_rgb,
  output logic        pixclk_out,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = cnt_w(H_TOTAL + 1);
  localparam int VW      = cnt_w(V_TOTAL + 1);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);
  localparam logic [HW-1:0]  X_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0]  Y_LAST   = VW'(V_ACTIVE - 1);
  localparam logic           SYNC_ACT = (SYNC_POL != 0);

  logic [HW-1:0]  h_cnt, x;
  logic [VW-1:0]  v_cnt, y;
  logic           hs_raw, vs_raw, de_raw, sof, bar_clr;
  logic [1:0]     pat_q;
  rgb_t           solid_q;
  logic [BPW-1:0] bar_px;
  logic [3:0]     bar_idx;
  rgb_t           pix;

  assign pixclk_out = pixclk_in;

  video_timing_ctrl #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .pixclk_in (pixclk_in),
    .rst_n     (rst_n),
    .init_over (init_over),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hs_raw    (hs_raw),
    .vs_raw    (vs_raw),
    .de_raw    (de_raw),
    .x         (x),
    .y         (y),
    .sof       (sof),
    .bar_clr   (bar_clr)
  );

  // Pattern controls are shadowed at the raster origin so a frame never tears.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= PAT_BARS;
      solid_q <= '0;
    end else if ((h_cnt == '0) && (v_cnt == '0)) begin
      pat_q   <= pat_sel;
      solid_q <= solid_rgb;
    end
  end

  // Bar position tracked by a pixel counter instead of dividing x by BAR_W;
  // bar_idx parks at 8 (black) for the leftover pixels past 8*BAR_W.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!init_over || bar_clr) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px  <= '0;
      if (bar_idx != 4'd8) bar_idx <= bar_idx + 4'd1;
    end else begin
      bar_px  <= bar_px + 1'b1;
    end
  end

`ifdef HDMI_PAT_MOVING_BOX_EN
  localparam logic [HW-1:0] BOX_XLIM = HW'(H_ACTIVE - BOX_SIZE);
  localparam logic [VW-1:0] BOX_YLIM = VW'(V_ACTIVE - BOX_SIZE);

  logic [HW-1:0] pos_x, disp_x, box_x, box_dx;
  logic [VW-1:0] pos_y, disp_y, box_y, box_dy;
  logic          dir_x, dir_y, in_box;

  // pos_* is the position for the coming frame; disp_* is what the current
  // frame shows. At frame_start the pending position is committed and the
  // next one is stepped, bouncing off the active-area edges.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      pos_x <= '0; pos_y <= '0; disp_x <= '0; disp_y <= '0;
      dir_x <= 1'b0; dir_y <= 1'b0;
    end else if (!init_over) begin
      pos_x <= '0; pos_y <= '0; disp_x <= '0; disp_y <= '0;
      dir_x <= 1'b0; dir_y <= 1'b0;
    end else if (sof) begin
      disp_x <= pos_x;
      disp_y <= pos_y;
      if (!dir_x) begin
        if (pos_x == BOX_XLIM) begin dir_x <= 1'b1; pos_x <= pos_x - 1'b1; end
        else                          pos_x <= pos_x + 1'b1;
      end else begin
        if (pos_x == '0) begin dir_x <= 1'b0; pos_x <= pos_x + 1'b1; end
        else                    pos_x <= pos_x - 1'b1;
      end
      if (!dir_y) begin
        if (pos_y == BOX_YLIM) begin dir_y <= 1'b1; pos_y <= pos_y - 1'b1; end
        else                          pos_y <= pos_y + 1'b1;
      end else begin
        if (pos_y == '0) begin dir_y <= 1'b0; pos_y <= pos_y + 1'b1; end
        else                    pos_y <= pos_y - 1'b1;
      end
    end
  end

  // On the first pixel the committed position is not yet in disp_*.
  always_comb begin
    box_x  = sof ? pos_x : disp_x;
    box_y  = sof ? pos_y : disp_y;
    box_dx = x - box_x;
    box_dy = y - box_y;
    in_box = (x >= box_x) && (box_dx < HW'(BOX_SIZE)) &&
             (y >= box_y) && (box_dy < VW'(BOX_SIZE));
  end
`endif

  // Pattern mux for the current counter state; blanked outside de.
  always_comb begin
    pix = '0;
    case (pat_q)
      PAT_BARS:  pix = bar_color(bar_idx);
      PAT_RAMP:  pix = {x[7:0], x[7:0], x[7:0]};
      PAT_GRID:  if ((x[5:0] == 6'd0) || (y[5:0] == 6'd0) || (x == X_LAST) || (y == Y_LAST))
                   pix = COL_WHITE;
      default:   pix = solid_q;
    endcase
`ifdef HDMI_PAT_MOVING_BOX_EN
    if (in_box) pix = COL_WHITE;
`endif
    if (!de_raw) pix = '0;
  end

  // Output registers; everything is zero (syncs included) while idle.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      hs_out <= 1'b0; vs_out <= 1'b0; de_out <= 1'b0; frame_start <= 1'b0;
      r_out  <= '0;   g_out  <= '0;   b_out  <= '0;
    end else if (!init_over) begin
      hs_out <= 1'b0; vs_out <= 1'b0; de_out <= 1'b0; frame_start <= 1'b0;
      r_out  <= '0;   g_out  <= '0;   b_out  <= '0;
    end else begin
      hs_out      <= hs_raw ? SYNC_ACT : ~SYNC_ACT;
      vs_out      <= vs_raw ? SYNC_ACT : ~SYNC_ACT;
      de_out      <= de_raw;
      frame_start <= sof;
      r_out       <= pix.r;
      g_out       <= pix.g;
      b_out       <= pix.b;
    end
  end

endmodule
